// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned only.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is a level request sampled in IDLE and held until done is seen;
  // done stays high while start stays high and drops one edge after start is sampled low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // Before iteration i the partial remainder is below 2^(i-1), so WIDTH-1 bits suffice
  // for what is carried between iterations; the full-width value goes straight to remainder.
  logic [WIDTH-2:0] prem_q, prem_d;
  logic [WIDTH-2:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
`endif

    shifted  = {prem_q, dvd_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {1'b0, dvs_q};
    borrow   = trial[WIDTH];
    next_rem = borrow ? shifted : trial[WIDTH-1:0];
    next_quo = {quo_q, ~borrow};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = S_RUN;
            dbz_d   = 1'b0;
            cnt_d   = CW'(WIDTH);
            prem_d  = '0;
            quo_d   = '0;
`ifdef DIV_SIGNED_EN
            dvd_d   = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
            dvs_d   = divisor[WIDTH-1] ? (~divisor + WIDTH'(1)) : divisor;
            neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_d = dividend[WIDTH-1];
`else
            dvd_d   = dividend;
            dvs_d   = divisor;
`endif
          end
        end
      end
      S_RUN: begin
        dvd_d  = dvd_q << 1;
        prem_d = next_rem[WIDTH-2:0];
        quo_d  = next_quo[WIDTH-2:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
`ifdef DIV_SIGNED_EN
          quotient_d  = neg_q_q ? (~next_quo + WIDTH'(1)) : next_quo;
          remainder_d = neg_r_q ? (~next_rem + WIDTH'(1)) : next_rem;
`else
          quotient_d  = next_quo;
          remainder_d = next_rem;
`endif
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  // Status is decoded from the state register only, so no input reaches an output combinationally.
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_dbz_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: plain integer division
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb;
    sa = 0;
    sb = 0;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      sa = int'(a);
      sb = int'(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`endif
      z = 1'b0;
    end
  endtask

  // driver: called at a negedge with start low; returns at a negedge in IDLE
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit pulse);
    logic [W-1:0] eq, er, got_q, got_r;
    logic         ez, got_z;
    int           cycles;
    int           lat;
    model(a, b, eq, er, ez);
    exp_q.push_back(eq);
    exp_q.push_back(er);
    exp_dbz_q.push_back(ez);
    lat = (b == '0) ? 0 : W;

    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = W'($urandom);
    divisor  = W'($urandom);
    check_eq("busy_after_load", 32'(busy), 32'(b != '0));
    cycles = 0;
    while (done !== 1'b1 && cycles < W + 4) begin
      check_eq("busy_run", 32'(busy), 32'd1);
      if (pulse && cycles == 3) start = 1'b0;
      if (pulse && cycles == 4) start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    check_eq("latency", 32'(cycles), 32'(lat));
    check_eq("done", 32'(done), 32'd1);
    check_eq("busy_in_done", 32'(busy), 32'd0);

    got_q = exp_q.pop_front();
    got_r = exp_q.pop_front();
    got_z = exp_dbz_q.pop_front();
    check_eq("quotient", 32'(quotient), 32'(got_q));
    check_eq("remainder", 32'(remainder), 32'(got_r));
    check_eq("div_by_zero", 32'(div_by_zero), 32'(got_z));

    for (int i = 0; i < hold; i++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_done", 32'(done), 32'd1);
      check_eq("hold_quotient", 32'(quotient), 32'(got_q));
      check_eq("hold_remainder", 32'(remainder), 32'(got_r));
    end

    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("done_fall", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("idle_quotient_held", 32'(quotient), 32'(got_q));
    check_eq("idle_dbz_held", 32'(div_by_zero), 32'(got_z));
  endtask

  // abort an operation 4 cycles into RUN with an asynchronous reset
  task automatic reset_mid_run();
    dividend = 8'd77;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("busy_before_abort", 32'(busy), 32'd1);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check_eq("abort_quotient", 32'(quotient), 32'd0);
    check_eq("abort_remainder", 32'(remainder), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_idle_busy", 32'(busy), 32'd0);
    check_eq("abort_idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_quotient", 32'(quotient), 32'd0);
    check_eq("rst_remainder", 32'(remainder), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
    check_eq("rst_state_idle", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_div(8'd100, 8'd7, 0, 1'b0);
    do_div(8'd255, 8'd1, 0, 1'b0);
    do_div(8'd3, 8'd10, 0, 1'b0);
    do_div(8'd5, 8'd0, 0, 1'b0);
    do_div(8'd9, 8'd3, 0, 1'b0);
    do_div(8'd100, 8'd7, 5, 1'b1);
    do_div(8'd255, 8'd128, 0, 1'b0);
    do_div(8'd254, 8'd255, 0, 1'b0);
    reset_mid_run();
    do_div(8'd200, 8'd9, 0, 1'b0);
`ifdef DIV_SIGNED_EN
    do_div(8'h9C, 8'd7, 0, 1'b0);
    do_div(8'd100, 8'hF9, 0, 1'b0);
    do_div(8'h80, 8'hFF, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      do_div(ra, rb, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential shift-subtract (restoring) integer divider that produces one quotient bit per clock. It is the inverse companion of the shift-add multiplier and uses the same start/done handshake, so both can sit behind the same arithmetic-unit sequencer. Control FSM, iteration counter and datapath registers live in this one module.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled in IDLE, must stay high until done is seen
- dividend  in  WIDTH  numerator; sampled only on the load edge
- divisor  in  WIDTH  denominator; sampled only on the load edge
- quotient  out  WIDTH  registered result; reset 0
- remainder  out  WIDTH  registered result; reset 0
- busy  out  1  high in RUN; reset 0
- done  out  1  high in DONE; reset 0
- div_by_zero  out  1  high in DONE when the loaded divisor was 0; reset 0

## Operation
- States: IDLE (reset state), RUN, DONE. The 2-bit encoding is free; any illegal state recovers to IDLE on the next edge.
- IDLE:
  - start=1 with divisor≠0: latch the operands, clear the partial remainder, set the counter to WIDTH, go to RUN.
  - start=1 with divisor=0: go directly to DONE; quotient = all ones, remainder = dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN, one iteration per cycle:
  - Form the trial value {partial_rem[WIDTH-2:0], dividend_msb} minus divisor, computed WIDTH+1 bits wide; shift the dividend register left by one.
  - Borrow=0: partial_rem takes the trial difference and the quotient LSB is 1.
  - Borrow=1: partial_rem takes the shifted value unchanged (restore) and the quotient LSB is 0.
  - The counter decrements; on the iteration where it reaches 0, quotient and remainder are written and the FSM goes to DONE.
- start is ignored in RUN; operand inputs are ignored outside the load edge.
- DONE: stay while start=1; go to IDLE on the edge where start=0.
- Results and div_by_zero hold their value from entry to DONE until the next load edge. div_by_zero clears on the next load edge.
- Arithmetic is unsigned unless DIV_SIGNED_EN is defined. remainder < divisor always. No overflow is possible in unsigned mode.
- rst at any time (including mid-RUN) aborts the operation: state goes to IDLE and all outputs go to 0 immediately.

## Timing
- Load edge L (IDLE, start=1): busy=1 after L.
- Normal division: done=1 and results are valid after edge L+WIDTH. Latency is WIDTH+1 edges from the first sampled start, with no data-dependent early exit.
- Divide by zero: done=1 after edge L, with busy never asserted.
- done falls one edge after start is sampled low. The earliest restart is the following edge in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement.
  - On the load edge, operand magnitudes are latched and the sign of each operand is recorded.
  - The quotient is truncated toward zero and negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Sign correction is applied in the final RUN cycle, so latency is unchanged.
  - A most-negative dividend divided by -1 wraps: quotient = 0x80 (WIDTH=8), remainder = 0, no flag.
  - Divide by zero gives the same outputs as in unsigned mode.
- DIV_SIGNED_EN undefined: purely unsigned; the sign logic is not built.

## Test plan
- WIDTH=8, 100/7, start held high → busy for 8 cycles; done after edge L+8 with quotient=14, remainder=2, div_by_zero=0.
- 255/1, then 3/10 issued back-to-back (start dropped for one cycle between them) → 255 r0, then 0 r3; the second done occurs after its own L+8.
- 5/0 → done after edge L, quotient=0xFF, remainder=5, div_by_zero=1, busy stays 0; the next 9/3 clears the flag and gives 3 r0.
- Hold start high 5 cycles in DONE → done and results stable; drop start → IDLE next edge; pulse start mid-RUN → no effect on result or timing.
- Assert rst at cycle 4 of RUN → all outputs 0 at once, IDLE; a new 200/9 afterwards gives 22 r2.
- DIV_SIGNED_EN: -100/7 → 0xF2 r0xFE; 100/-7 → 0xF2 r0x02; -128/-1 → 0x80 r0.
